// File: rtl/pwm_defs.sv
// Definitions shared by the PWM generator and the PWM capture block.
package pwm_defs;

    localparam int PWM_W    = 13;
    localparam int PWM_FREQ = 4000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_MEAS  = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a registered edge pulse
// that is aligned with the first cycle of the new synchronized level.
module pwm_sync_edge #(
    parameter bit FALL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic edge_o
);

    logic meta_q, sync_q, level_q, edge_q;

    // Flops reset high so that a released reset never looks like a falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            edge_q  <= 1'b0;
        end else begin
            meta_q  <= pin_i;
            sync_q  <= meta_q;
            level_q <= sync_q;
            edge_q  <= FALL ? (level_q & ~sync_q) : (~level_q & sync_q);
        end
    end

    assign level_o = level_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and low-time of an active-low PWM input once per cycle and
// reports the low-time ramp direction, rollover and a stuck-input condition.
module pwm_capture
    import pwm_defs::*;
#(
    parameter int           W   = PWM_W,
    parameter logic [W-1:0] TMO = 13'd8191
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         PWM_IN,
    output logic [W-1:0] PERIOD,
    output logic [W-1:0] LOW_CNT,
    output logic         VALID,
    output logic         DIR,
    output logic         WRAP,
    output logic         STUCK
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic s, fe;

    pwm_sync_edge #(.FALL(1'b1)) u_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .pin_i   (PWM_IN),
        .level_o (s),
        .edge_o  (fe)
    );

    state_e       state_q, state_d;
    logic [W-1:0] cnt_per_q, cnt_per_d;
    logic [W-1:0] cnt_low_q, cnt_low_d;
    logic [W-1:0] prev_low_q, prev_low_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] low_q, low_d;
    logic         valid_q, valid_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic         stuck_q, stuck_d;

    logic [W-1:0] new_period;
    logic [W-1:0] delta;
    logic         timeout;

    assign new_period = (cnt_per_q == CNT_MAX) ? CNT_MAX : cnt_per_q + W'(1);
    assign delta      = (cnt_low_q >= prev_low_q) ? cnt_low_q - prev_low_q
                                                  : prev_low_q - cnt_low_q;
    assign timeout    = (cnt_per_q == TMO - W'(1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        cnt_per_d  = (cnt_per_q == CNT_MAX) ? cnt_per_q : cnt_per_q + W'(1);
        cnt_low_d  = (!s && cnt_low_q != CNT_MAX) ? cnt_low_q + W'(1) : cnt_low_q;
        state_d    = state_q;
        prev_low_d = prev_low_q;
        period_d   = period_q;
        low_d      = low_q;
        valid_d    = 1'b0;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
        stuck_d    = stuck_q;

        if (fe) begin
            cnt_per_d = '0;
            cnt_low_d = W'(1);
            stuck_d   = 1'b0;
            if (state_q == ST_IDLE) begin
                state_d = ST_FIRST;
            end else begin
                state_d    = ST_MEAS;
                period_d   = new_period;
                low_d      = cnt_low_q;
                prev_low_d = cnt_low_q;
                valid_d    = 1'b1;
                // A jump larger than half a period can only be the ramp rolling over.
                if (state_q == ST_MEAS) begin
                    if (delta > (new_period >> 1)) begin
                        wrap_d = 1'b1;
                    end else if (cnt_low_q > prev_low_q) begin
                        dir_d = 1'b1;
                    end else if (cnt_low_q < prev_low_q) begin
                        dir_d = 1'b0;
                    end
                end
            end
        end else if (timeout) begin
            state_d  = ST_IDLE;
            stuck_d  = 1'b1;
            period_d = '0;
            low_d    = s ? '0 : CNT_MAX;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_per_q  <= '0;
            cnt_low_q  <= '0;
            prev_low_q <= '0;
            period_q   <= '0;
            low_q      <= '0;
            valid_q    <= 1'b0;
            dir_q      <= 1'b1;
            wrap_q     <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_per_q  <= cnt_per_d;
            cnt_low_q  <= cnt_low_d;
            prev_low_q <= prev_low_d;
            period_q   <= period_d;
            low_q      <= low_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
            stuck_q    <= stuck_d;
        end
    end

    assign PERIOD  = period_q;
    assign LOW_CNT = low_q;
    assign VALID   = valid_q;
    assign DIR     = dir_q;
    assign WRAP    = wrap_q;
    assign STUCK   = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and random PWM waveforms
// compared against a cycle-level model of the measured quantities.
module tb_pwm_capture;
    import pwm_defs::*;

    localparam int W    = PWM_W;
    localparam int MAXV = (1 << W) - 1;

    logic         CLK    = 1'b0;
    logic         RST    = 1'b1;
    logic         PWM_IN = 1'b1;
    logic [W-1:0] PERIOD, LOW_CNT;
    logic         VALID, DIR, WRAP, STUCK;

    pwm_capture dut (
        .CLK     (CLK),
        .RST     (RST),
        .PWM_IN  (PWM_IN),
        .PERIOD  (PERIOD),
        .LOW_CNT (LOW_CNT),
        .VALID   (VALID),
        .DIR     (DIR),
        .WRAP    (WRAP),
        .STUCK   (STUCK)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_valid    = 0;
    int wrap_stray = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model: one expected report per falling edge, describing the
    // PWM cycle that this edge closes.
    typedef struct {
        int period;
        int low;
        int dir;
        int wrap;
        int fall_cyc;
    } exp_t;

    exp_t q[$];
    int falls_since_idle = 0;
    int ref_low          = 0;
    int m_dir            = 1;
    int cur_l            = 0;
    int cur_h            = 0;

    task automatic fall_event();
        exp_t e;
        int   d;
        int   ad;
        if (falls_since_idle >= 1) begin
            e.period = cur_l + cur_h;
            e.low    = cur_l;
            e.wrap   = 0;
            if (falls_since_idle >= 2) begin
                d  = cur_l - ref_low;
                ad = (d < 0) ? -d : d;
                if (ad > e.period / 2) e.wrap = 1;
                else if (d > 0)        m_dir  = 1;
                else if (d < 0)        m_dir  = 0;
            end
            e.dir      = m_dir;
            e.fall_cyc = cyc;
            ref_low    = cur_l;
            q.push_back(e);
        end
        falls_since_idle++;
    endtask

    task automatic go_low(input int l);
        @(negedge CLK);
        fall_event();
        PWM_IN = 1'b0;
        cur_l  = l;
        cur_h  = 0;
        repeat (l - 1) @(negedge CLK);
    endtask

    task automatic go_high(input int h);
        @(negedge CLK);
        PWM_IN = 1'b1;
        cur_h  = h;
        repeat (h - 1) @(negedge CLK);
    endtask

    task automatic pwm_cycle(input int l, input int h);
        go_low(l);
        go_high(h);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_period"}, PERIOD, 0);
        check({tag, "_low"},    LOW_CNT, 0);
        check({tag, "_valid"},  VALID, 0);
        check({tag, "_dir"},    DIR, 1);
        check({tag, "_wrap"},   WRAP, 0);
        check({tag, "_stuck"},  STUCK, 0);
    endtask

    // Monitor: every VALID must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (VALID) begin
                    n_valid++;
                    if (q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("period",  PERIOD,  e.period);
                        check("low_cnt", LOW_CNT, e.low);
                        check("dir",     DIR,     e.dir);
                        check("wrap",    WRAP,    e.wrap);
                        check("latency", cyc - e.fall_cyc, 4);
                    end
                end else if (WRAP) begin
                    wrap_stray++;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int l;
        int last_l;
        int v0;

        repeat (3) @(negedge CLK);
        check_reset_values("rst_init");
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Hand-built waveform: period 10, low 3.
        repeat (3) pwm_cycle(3, 7);

        // Slow ramp up at the generator frequency.
        for (int i = 100; i <= 103; i++) pwm_cycle(i, PWM_FREQ - i);

        // Ramp down.
        for (int i = 110; i >= 107; i--) pwm_cycle(i, 1000 - i);

        // Ramp through rollover.
        pwm_cycle(997, 3);
        pwm_cycle(998, 2);
        pwm_cycle(999, 1);
        pwm_cycle(1, 999);
        pwm_cycle(2, 998);

        // Random waveforms, with occasional repeated low-time.
        last_l = 1;
        for (int i = 0; i < 15; i++) begin
            p = $urandom_range(600, 4);
            l = $urandom_range(p - 1, 1);
            if (($urandom % 4) == 0 && last_l < p) l = last_l;
            pwm_cycle(l, p - l);
            last_l = l;
        end

        // Asynchronous reset in the middle of a high phase.
        go_low(20);
        go_high(40);
        check("queue_empty_before_rst", q.size(), 0);
        #2 RST = 1'b1;
        #1 check_reset_values("rst_async");
        repeat (3) @(negedge CLK);
        RST              = 1'b0;
        falls_since_idle = 0;
        m_dir            = 1;
        repeat (4) @(negedge CLK);
        v0 = n_valid;
        pwm_cycle(5, 15);
        check("no_valid_after_1st_fe", n_valid - v0, 0);
        pwm_cycle(7, 13);
        check("valid_after_2nd_fe", n_valid - v0, 1);
        pwm_cycle(6, 14);

        // Input stuck high.
        go_low(50);
        go_high(8000);
        check("stuck_high_early", STUCK, 0);
        repeat (300) @(negedge CLK);
        falls_since_idle = 0;
        check("stuck_high",        STUCK, 1);
        check("stuck_high_low",    LOW_CNT, 0);
        check("stuck_high_period", PERIOD, 0);
        v0 = n_valid;
        repeat (700) @(negedge CLK);
        check("stuck_high_no_valid", n_valid - v0, 0);

        // Input stuck low.
        @(negedge CLK);
        fall_event();
        PWM_IN = 1'b0;
        repeat (6) @(negedge CLK);
        check("stuck_clear_on_fe", STUCK, 0);
        repeat (8300) @(negedge CLK);
        falls_since_idle = 0;
        check("stuck_low",        STUCK, 1);
        check("stuck_low_low",    LOW_CNT, MAXV);
        check("stuck_low_period", PERIOD, 0);
        repeat (700) @(negedge CLK);
        go_high(30);

        // Recovery after stuck.
        pwm_cycle(4, 6);
        pwm_cycle(5, 5);
        pwm_cycle(6, 4);
        go_low(5);
        go_high(20);
        repeat (10) @(negedge CLK);

        check("pending_expectations", q.size(), 0);
        check("wrap_without_valid", wrap_stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
